// File: rtl/rand_pkg.sv
// Shared definitions for the random-candidate path.
//   state_t      : controller states (IDLE, COLLECT, FIX, HOLD)
//   DEF_*_WIDTH  : default candidate / random-source widths
//   forced_mask  : bit pattern OR-ed into every candidate (top two bits and LSB)
// Candidate widths up to MASK_MAX bits are supported by forced_mask.
package rand_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FIX     = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam int DEF_WORD_WIDTH = 32;
    localparam int DEF_RAND_WIDTH = 16;
    localparam int MASK_MAX       = 256;

    // Top bit set keeps the candidate full-width, the next bit keeps the
    // product of two such candidates full-width, bit 0 makes it odd.
    function automatic logic [MASK_MAX-1:0] forced_mask(input int w);
        logic [MASK_MAX-1:0] m;
        m        = '0;
        m[w-1]   = 1'b1;
        m[w-2]   = 1'b1;
        m[0]     = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/prime_candidate_gen_mod3_reduce.sv
// mod3_reduce: combinational residue of an unsigned value modulo 3.
//   value   in  WIDTH  operand
//   residue out 2      value mod 3 (0, 1 or 2)
// Since 4 == 1 (mod 3), the residue equals the sum of the base-4 digits
// mod 3, so the value is folded two bits at a time with a mod-3 adder.
module mod3_reduce #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    output logic [1:0]       residue
);

    localparam int PW = ((WIDTH + 1) / 2) * 2;

    logic [PW-1:0] padded;
    assign padded = PW'(value);

    logic [1:0] acc;
    logic [2:0] sum;

    always_comb begin
        acc = 2'd0;
        sum = 3'd0;
        for (int i = 0; i < PW / 2; i++) begin
            sum = {1'b0, acc} + {1'b0, padded[2*i +: 2]};
            acc = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
        end
        residue = acc;
    end

endmodule

// File: rtl/prime_candidate_gen.sv
// prime_candidate_gen: samples a 1-bit/cycle LFSR word every RAND_WIDTH cycles
// so successive chunks share no bits, packs NUM_CHUNKS chunks (first chunk in
// the MS position), forces the top two bits and bit 0, and offers the result
// on a valid/ready handshake. One candidate per start request.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   rand_in    in   RAND_WIDTH  current LFSR state
//   start      in   request a candidate (honoured in IDLE only)
//   busy       out  high whenever not IDLE
//   cand_valid out  candidate available
//   cand_ready in   downstream accepts candidate
//   candidate  out  WORD_WIDTH  packed candidate, held until next FIX
//
// Optional feature: define PRIME_CAND_DIV3_FILTER_EN to reject candidates
// divisible by 3; a rejected attempt restarts collection from scratch.
//
// WORD_WIDTH must be a multiple of RAND_WIDTH, at least 2*RAND_WIDTH and
// no larger than rand_pkg::MASK_MAX; RAND_WIDTH must be even.
module prime_candidate_gen
    import rand_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int RAND_WIDTH = DEF_RAND_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RAND_WIDTH-1:0] rand_in,
    input  logic                  start,
    output logic                  busy,
    output logic                  cand_valid,
    input  logic                  cand_ready,
    output logic [WORD_WIDTH-1:0] candidate
);

    localparam int NUM_CHUNKS = WORD_WIDTH / RAND_WIDTH;
    localparam int GAP_W      = $clog2(RAND_WIDTH);
    localparam int CHUNK_W    = $clog2(NUM_CHUNKS + 1);

    localparam logic [GAP_W-1:0]      GAP_LAST   = GAP_W'(RAND_WIDTH - 1);
    localparam logic [CHUNK_W-1:0]    CHUNK_LAST = CHUNK_W'(NUM_CHUNKS - 1);
    localparam logic [MASK_MAX-1:0]   MASK_ALL   = forced_mask(WORD_WIDTH);
    localparam logic [WORD_WIDTH-1:0] MASK       = MASK_ALL[WORD_WIDTH-1:0];

    state_t                state;
    logic [GAP_W-1:0]      gap_cnt;
    logic [CHUNK_W-1:0]    chunk_cnt;
    logic [WORD_WIDTH-1:0] shreg;
    logic [WORD_WIDTH-1:0] forced;
    logic                  reject;

    assign forced = shreg | MASK;

`ifdef PRIME_CAND_DIV3_FILTER_EN
    logic [1:0] residue;

    mod3_reduce #(
        .WIDTH (WORD_WIDTH)
    ) u_mod3 (
        .value   (forced),
        .residue (residue)
    );

    assign reject = (residue == 2'd0);
`else
    assign reject = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            chunk_cnt  <= '0;
            shreg      <= '0;
            candidate  <= '0;
            cand_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= COLLECT;
                        busy      <= 1'b1;
                        gap_cnt   <= '0;
                        chunk_cnt <= '0;
                        shreg     <= '0;
                    end
                end

                COLLECT: begin
                    // Capture only on the wrap edge: the LFSR has then
                    // shifted a whole word since the previous capture.
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt   <= '0;
                        shreg     <= {shreg[WORD_WIDTH-RAND_WIDTH-1:0], rand_in};
                        chunk_cnt <= chunk_cnt + 1'b1;
                        if (chunk_cnt == CHUNK_LAST)
                            state <= FIX;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                FIX: begin
                    if (reject) begin
                        // Retry with a fully fresh set of chunks.
                        state     <= COLLECT;
                        gap_cnt   <= '0;
                        chunk_cnt <= '0;
                        shreg     <= '0;
                    end else begin
                        candidate  <= forced;
                        cand_valid <= 1'b1;
                        state      <= HOLD;
                    end
                end

                HOLD: begin
                    if (cand_ready) begin
                        cand_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: begin
                    state      <= IDLE;
                    cand_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prime_candidate_gen.sv
// Self-checking bench for prime_candidate_gen (default 32/16 configuration).
// A driver issues requests with a pre-planned rand_in sequence; a reference
// model derives the expected candidate and valid latency from that sequence
// and pushes them to a scoreboard; a monitor pops on each rising cand_valid.
module tb_prime_candidate_gen;

    localparam int W   = 32;
    localparam int R   = 16;
    localparam int NC  = W / R;
    localparam int ATT = 12;          // attempts planned per request
    localparam int SEQ = 512;
`ifdef PRIME_CAND_DIV3_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] cand;
        int           start_cyc;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [R-1:0] rand_in;
    logic         start;
    logic         busy;
    logic         cand_valid;
    logic         cand_ready;
    logic [W-1:0] candidate;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    exp_t sb[$];
    logic [R-1:0] rseq [SEQ];

    prime_candidate_gen #(.WORD_WIDTH(W), .RAND_WIDTH(R)) dut (
        .clk        (clk),
        .rst        (rst),
        .rand_in    (rand_in),
        .start      (start),
        .busy       (busy),
        .cand_valid (cand_valid),
        .cand_ready (cand_ready),
        .candidate  (candidate)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: sampled 1 time unit after each active edge.
    logic         pv = 1'b0;
    logic [W-1:0] pcand = '0;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (cand_valid && !pv) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("candidate", candidate, e.cand);
                    check("valid_latency", cyc - e.start_cyc, e.lat);
                end
            end
            if (cand_valid && pv)
                check("hold_stable", candidate, pcand);
            if (pv && !cand_valid && !cand_ready)
                check("valid_dropped_without_ready", 0, 1);
            pv    = cand_valid;
            pcand = candidate;
        end
    end

    // Reference model: chunk k of attempt a is the rand value present at
    // edge a*(NC*R+1) + k*R relative to the start edge.
    task automatic model(output logic [W-1:0] cand, output int lat);
        longint unsigned c;
        int base;
        lat  = -1;
        cand = '0;
        base = 0;
        for (int a = 0; a < ATT; a++) begin
            c = 0;
            for (int k = 1; k <= NC; k++)
                c = (c << R) | longint'(rseq[base + k*R]);
            c = c | (64'd1 << (W-1)) | (64'd1 << (W-2)) | 64'd1;
            if (!FILT || (c % 3) != 0) begin
                cand = c[W-1:0];
                lat  = base + NC*R + 1;
                return;
            end
            base += NC*R + 1;
        end
    endtask

    // mode: 0 const 1234, 1 ramp from 0, 2 const FFFF, 3 0003 then 1234, 4 random
    task automatic run(input int mode, input int rdly);
        logic [W-1:0] c;
        int lat, vcnt;
        bit done;
        exp_t e;
        lat = -1;
        while (lat < 0) begin
            for (int i = 0; i < SEQ; i++) begin
                case (mode)
                    0:       rseq[i] = 16'h1234;
                    1:       rseq[i] = R'(i);
                    2:       rseq[i] = 16'hFFFF;
                    3:       rseq[i] = (i < NC*R+1) ? 16'h0003 : 16'h1234;
                    default: rseq[i] = R'($urandom);
                endcase
            end
            model(c, lat);
        end
        @(negedge clk);
        start      = 1'b1;
        rand_in    = rseq[0];
        cand_ready = (rdly == 0);
        e.cand = c; e.start_cyc = cyc + 1; e.lat = lat;
        sb.push_back(e);
        vcnt = 0;
        done = 1'b0;
        for (int i = 1; i < 2000 && !done; i++) begin
            @(negedge clk);
            start   = 1'b0;
            rand_in = rseq[(i < SEQ) ? i : SEQ-1];
            if (i == 1) check("busy_after_start", busy, 1);
            if (cand_valid) begin
                vcnt++;
                if (vcnt == 2 && rdly > 2) start = 1'b1;  // must be ignored
                if (vcnt > rdly) cand_ready = 1'b1;
            end else if (vcnt > 0) begin
                done = 1'b1;
            end
        end
        if (!done) begin
            check("handshake_timeout", 0, 1);
            return;
        end
        check("valid_cycles", vcnt, rdly + 1);
        check("busy_after_handshake", busy, 0);
        check("candidate_retained", candidate, c);
        cand_ready = 1'b0;
        @(negedge clk);
        check("idle_after_handshake", {busy, cand_valid}, 0);
    endtask

    task automatic reset_mid;
        @(negedge clk);
        start   = 1'b1;
        rand_in = R'($urandom);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start   = 1'b0;
            rand_in = R'($urandom);
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", cand_valid, 0);
        check("rst_candidate", candidate, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        cand_ready = 1'b0;
        rand_in    = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_valid", cand_valid, 0);
        check("reset_candidate", candidate, 0);
        rst = 1'b0;

        run(0, 0);
        run(1, 0);
        run(0, 10);
        reset_mid();
        run(2, 0);
        run(3, 0);
        for (int t = 0; t < 25; t++)
            run(4, int'($urandom_range(0, 5)));

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
